// File: rtl/lcd1602_receiver.sv
// lcd1602_receiver: HD44780-style 8-bit bus responder mirroring a 2x16 character buffer
module lcd1602_receiver #(
    parameter int BUSY_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rs,
    input  logic       rw,
    input  logic       enable,
    input  logic [7:0] data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] ac,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       busy,
    output logic       wr_strobe,
    output logic       overrun,
    output logic       unsupported
);
    typedef enum logic [1:0] {IDLE, EXEC, CLEAR} state_t;
    localparam int CW = $clog2(BUSY_CYCLES + 33);
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          enable_q, pend_q, pend_d;
    logic [9:0]    cmd_q, cmd_d;
    logic [6:0]    ac_q, ac_d;
    logic          inc_q, inc_d, ovr_q, ovr_d, unsup_q, unsup_d;
    logic [2:0]    dcb_q, dcb_d;
    logic [7:0]    buf_q [32];
    logic [7:0]    rd_q;
    logic          we, fall;
    logic [4:0]    wa;
    logic [7:0]    wd;
    logic [7:0]    cmd_b;

    // DDRAM counter step across the two 40-byte line windows (0x00-0x27, 0x40-0x67)
    function automatic logic [6:0] step(input logic [6:0] a, input logic up);
        return up ? ((a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1)
                  : ((a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1);
    endfunction

    assign fall        = enable_q & ~enable;
    assign cmd_b       = cmd_q[7:0];
    assign busy        = state_q != IDLE;
    assign wr_strobe   = state_q == EXEC && pend_q && cmd_q[9] && !cmd_q[8];
    assign rd_char     = rd_q;
    assign ac          = ac_q;
    assign {display_on, cursor_on, blink_on} = dcb_q;
    assign overrun     = ovr_q;
    assign unsupported = unsup_q;

    // Next-state: latch a transaction in IDLE, apply it on EXEC entry, sweep cells in CLEAR
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        cmd_d   = cmd_q;
        ac_d    = ac_q;
        inc_d   = inc_q;
        dcb_d   = dcb_q;
        ovr_d   = ovr_q | (fall && state_q != IDLE);
        unsup_d = unsup_q;
        we      = 1'b0;
        wa      = cnt_q[4:0];
        wd      = 8'h20;
        case (state_q)
            IDLE: if (fall) begin
                cmd_d   = {rs, rw, data};
                cnt_d   = '0;
                state_d = (!rs && !rw && data == 8'h01) ? CLEAR : EXEC;
                pend_d  = !(!rs && !rw && data == 8'h01);
            end
            CLEAR: begin
                we      = 1'b1;
                ac_d    = 7'h00;
                cnt_d   = (cnt_q[4:0] == 5'd31) ? '0 : cnt_q + 1'b1;
                state_d = (cnt_q[4:0] == 5'd31) ? EXEC : CLEAR;
            end
            EXEC: begin
                pend_d  = 1'b0;
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(BUSY_CYCLES - 1)) ? IDLE : EXEC;
                if (pend_q) begin
                    if (cmd_q[8]) unsup_d = 1'b1;
                    else if (cmd_q[9]) begin
                        we   = ac_q[5:4] == 2'b00;
                        wa   = {ac_q[6], ac_q[3:0]};
                        wd   = cmd_b;
                        ac_d = step(ac_q, inc_q);
                    end
                    else if (cmd_b[7]) begin
                        if (cmd_b[5:0] <= 6'h27) ac_d = cmd_b[6:0];
                        else unsup_d = 1'b1;
                    end
                    else if (cmd_b[6]) unsup_d = 1'b1;
                    else if (!cmd_b[5]) begin
                        if (cmd_b[4]) ac_d = cmd_b[3] ? ac_q : step(ac_q, cmd_b[2]);
                        else if (cmd_b[3]) dcb_d = cmd_b[2:0];
                        else if (cmd_b[2]) inc_d = cmd_b[1];
                        else if (cmd_b[1]) ac_d = 7'h00;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, control registers and the character buffer with its registered read port
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            enable_q <= 1'b0;
            pend_q   <= 1'b0;
            cmd_q    <= '0;
            ac_q     <= 7'h00;
            inc_q    <= 1'b1;
            dcb_q    <= 3'b000;
            ovr_q    <= 1'b0;
            unsup_q  <= 1'b0;
            rd_q     <= 8'h20;
            for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            enable_q <= enable;
            pend_q   <= pend_d;
            cmd_q    <= cmd_d;
            ac_q     <= ac_d;
            inc_q    <= inc_d;
            dcb_q    <= dcb_d;
            ovr_q    <= ovr_d;
            unsup_q  <= unsup_d;
            rd_q     <= buf_q[rd_addr];
            if (we) buf_q[wa] <= wd;
        end
    end
endmodule

// File: tb/tb_lcd1602_receiver.sv
// tb_lcd1602_receiver: random and directed bus transactions checked against a transaction-level model
module tb_lcd1602_receiver;
    localparam int B = 4;
    logic       clk = 0, reset = 1, rs = 0, rw = 0, enable = 0;
    logic [7:0] data = 0;
    logic [4:0] rd_addr = 0;
    logic [7:0] rd_char;
    logic [6:0] ac;
    logic       display_on, cursor_on, blink_on, busy, wr_strobe, overrun, unsupported;
    int         n_vec = 0, n_err = 0;

    logic [7:0] m_cell [32];
    int         m_ac;
    bit         m_inc, m_uns, m_ovr;
    bit   [2:0] m_dcb;

    lcd1602_receiver #(.BUSY_CYCLES(B)) dut (
        .clk(clk), .reset(reset), .rs(rs), .rw(rw), .enable(enable), .data(data),
        .rd_addr(rd_addr), .rd_char(rd_char), .ac(ac), .display_on(display_on),
        .cursor_on(cursor_on), .blink_on(blink_on), .busy(busy), .wr_strobe(wr_strobe),
        .overrun(overrun), .unsupported(unsupported)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Address counter as a position on an 80-entry ring: 0..39 line 0, 40..79 line 1
    function automatic int ac_step(input int a, input bit up);
        int p = (a < 64) ? a : a - 24;
        p = (p + (up ? 1 : 79)) % 80;
        return (p < 40) ? p : p + 24;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
        m_ac = 0; m_inc = 1; m_uns = 0; m_ovr = 0; m_dcb = 0;
    endtask

    function automatic int model_apply(input bit r_s, input bit r_w, input logic [7:0] d);
        int v = d;
        if (r_w) m_uns = 1;
        else if (r_s) begin
            if (m_ac % 64 < 16) m_cell[(m_ac >= 64 ? 16 : 0) + m_ac % 16] = d;
            m_ac = ac_step(m_ac, m_inc);
        end
        else if (v == 1) begin
            for (int i = 0; i < 32; i++) m_cell[i] = 8'h20;
            m_ac = 0;
            return 32 + B;
        end
        else if (v >= 128) begin
            if ((v - 128) <= 'h27 || ((v - 128) >= 'h40 && (v - 128) <= 'h67)) m_ac = v - 128;
            else m_uns = 1;
        end
        else if (v >= 64) m_uns = 1;
        else if (v >= 32) ;
        else if (v >= 16) begin if ((v & 8) == 0) m_ac = ac_step(m_ac, (v & 4) != 0); end
        else if (v >= 8) m_dcb = 3'(v & 7);
        else if (v >= 4) m_inc = (v & 2) != 0;
        else if (v >= 2) m_ac = 0;
        return B;
    endfunction

    task automatic pulse(input bit r_s, input bit r_w, input logic [7:0] d);
        @(negedge clk);
        rs = r_s; rw = r_w; data = d; enable = 1;
        @(negedge clk);
        enable = 0;
    endtask

    task automatic chk_state();
        chk("ac", 32'(ac), 32'(m_ac));
        chk("dcb", 32'({display_on, cursor_on, blink_on}), 32'(m_dcb));
        chk("unsupported", 32'(unsupported), 32'(m_uns));
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic xact(input bit r_s, input bit r_w, input logic [7:0] d);
        int exp_len, n;
        exp_len = model_apply(r_s, r_w, d);
        pulse(r_s, r_w, d);
        @(negedge clk);
        chk("wr_strobe_on", 32'(wr_strobe), 32'(r_s & ~r_w));
        n = 0;
        while (busy && n < 300) begin
            n++;
            @(negedge clk);
            if (n == 1) chk("wr_strobe_off", 32'(wr_strobe), 0);
        end
        chk($sformatf("busy_len %0d/%0d/%02h", r_s, r_w, d), n, exp_len);
        chk_state();
    endtask

    task automatic dump();
        for (int i = 0; i < 32; i++) begin
            rd_addr = 5'(i);
            @(negedge clk);
            chk($sformatf("cell%0d", i), 32'(rd_char), 32'(m_cell[i]));
        end
    endtask

    initial begin
        int n;
        int r;
        logic [7:0] d;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 0;
        chk("reset_rd_char", 32'(rd_char), 32'h20);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_wr_strobe", 32'(wr_strobe), 0);
        chk_state();
        dump();
        // 1: single data write
        xact(1, 0, 8'h48);
        dump();
        // 2: jump to line 1, write
        xact(0, 0, 8'hC0);
        xact(1, 0, 8'h41);
        rd_addr = 5'h10; @(negedge clk);
        chk("cell16_direct", 32'(rd_char), 32'h41);
        // 3: invisible column and wraps
        xact(0, 0, 8'hA7);
        xact(1, 0, 8'h55);
        xact(0, 0, 8'hE7);
        xact(1, 0, 8'h66);
        dump();
        // 4: fill then clear
        for (int i = 0; i < 20; i++) xact(1, 0, 8'(8'h61 + i));
        xact(0, 0, 8'h01);
        dump();
        // 5: decrement mode and display control
        xact(0, 0, 8'h04);
        xact(0, 0, 8'hC0);
        xact(1, 0, 8'h31);
        xact(0, 0, 8'h0D);
        dump();
        // 6: overrun - second strobe lands during execution and is ignored
        void'(model_apply(1, 0, 8'h77));
        m_ovr = 1;
        pulse(1, 0, 8'h77);
        pulse(1, 0, 8'h88);
        wait_idle(n);
        chk("overrun_idle", 32'(n < 300), 1);
        chk_state();
        dump();
        // reset in the middle of a clear
        for (int i = 0; i < 5; i++) xact(1, 0, 8'(8'h30 + i));
        pulse(0, 0, 8'h01);
        repeat (10) @(negedge clk);
        reset = 1;
        @(negedge clk);
        reset = 0;
        model_reset();
        chk("midclear_busy", 32'(busy), 0);
        @(negedge clk);
        chk("midclear_busy2", 32'(busy), 0);
        chk_state();
        dump();
        // randomized traffic
        for (int k = 0; k < 150; k++) begin
            r = $urandom_range(0, 99);
            if (r < 50) xact(1, 0, 8'($urandom));
            else if (r < 55) xact(1'($urandom), 1, 8'($urandom));
            else if (r < 58) xact(0, 0, 8'h01);
            else begin
                d = 8'($urandom);
                if (d == 8'h01) d = 8'h02;
                xact(0, 0, d);
            end
            if (k % 15 == 14) dump();
        end
        dump();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
